// File: rtl/piano_pkg.sv
// Shared constants and state encoding for the song replay path.
package piano_pkg;

    // Song geometry: one-hot key lane per row, all-zero means rest.
    localparam int ROW_W               = 4;
    localparam int NUM_ROWS            = 31;
    localparam int SONG_W              = NUM_ROWS * ROW_W;
    localparam int CNT_W               = $clog2(NUM_ROWS + 1);
    localparam int STEP_CYCLES_DEFAULT = 4;

    // Streamer states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        OFFER     = 2'd2,
        DONE      = 2'd3
    } stream_state_t;

endpackage

// File: rtl/song_row_streamer_step_timer.sv
// Loadable down-counter pacing the gap between rows.
// The expiry flag is registered, so it rises one cycle after the count
// reaches zero; the owner sees it on the following edge.
module step_timer #(
    parameter int STEP_CYCLES = piano_pkg::STEP_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [TW-1:0] count_reg;
    logic          expired_reg;

    // Count down while enabled; a load restarts the interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg   <= '0;
            expired_reg <= 1'b0;
        end else if (load) begin
            count_reg   <= TW'(STEP_CYCLES - 1);
            expired_reg <= 1'b0;
        end else if (en) begin
            if (count_reg != '0) begin
                count_reg <= count_reg - TW'(1);
            end
            expired_reg <= (count_reg == '0);
        end
    end

    assign expired = expired_reg;

endmodule

// File: rtl/song_row_streamer.sv
// Replays a latched packed song one row at a time over valid/ready,
// pacing rows with step_timer and tracking progress and malformed rows.
module song_row_streamer #(
    parameter int NUM_ROWS    = piano_pkg::NUM_ROWS,
    parameter int ROW_W       = piano_pkg::ROW_W,
    parameter int STEP_CYCLES = piano_pkg::STEP_CYCLES_DEFAULT,
    parameter int CNT_W       = $clog2(NUM_ROWS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_ROWS*ROW_W-1:0] song,
    input  logic                      start,
    input  logic                      pause,
    output logic [ROW_W-1:0]          row_out,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic [CNT_W-1:0]          rows_left,
    output logic                      busy,
    output logic                      done,
    output logic                      bad_row
);

    import piano_pkg::*;

    localparam int SW = NUM_ROWS * ROW_W;

    stream_state_t    state_reg, state_next;
    logic [SW-1:0]    shreg_reg, shreg_next;
    logic [ROW_W-1:0] row_out_reg, row_out_next;
    logic             row_valid_reg, row_valid_next;
    logic [CNT_W-1:0] rows_left_reg, rows_left_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             bad_row_reg, bad_row_next;
    logic             timer_load;
    logic             timer_expired;
    logic             handshake;
    logic             row_multi_hot;

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .en     (!pause),
        .expired(timer_expired)
    );

    assign handshake     = row_valid_reg && row_ready;
    // A legal row is one-hot or zero; clearing the lowest set bit leaves
    // something only when two or more bits were set.
    assign row_multi_hot = (row_out_reg & (row_out_reg - ROW_W'(1))) != '0;

    // State, data and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            row_out_reg   <= '0;
            row_valid_reg <= 1'b0;
            rows_left_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            bad_row_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            row_out_reg   <= row_out_next;
            row_valid_reg <= row_valid_next;
            rows_left_reg <= rows_left_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            bad_row_reg   <= bad_row_next;
        end
    end

    // Next-state and next-output logic; start overrides everything,
    // including a handshake landing in the same cycle.
    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        row_out_next   = row_out_reg;
        row_valid_next = row_valid_reg;
        rows_left_next = rows_left_reg;
        bad_row_next   = bad_row_reg;
        timer_load     = 1'b0;

        if (start) begin
            shreg_next     = song;
            rows_left_next = CNT_W'(NUM_ROWS);
            bad_row_next   = 1'b0;
            row_valid_next = 1'b0;
            timer_load     = 1'b1;
            state_next     = WAIT_TICK;
        end else begin
            case (state_reg)
                IDLE: begin
                    row_valid_next = 1'b0;
                end
                WAIT_TICK: begin
                    if (!pause && timer_expired) begin
                        row_out_next   = shreg_reg[SW-1 -: ROW_W];
                        row_valid_next = 1'b1;
                        state_next     = OFFER;
                    end
                end
                OFFER: begin
                    if (handshake) begin
                        shreg_next     = shreg_reg << ROW_W;
                        row_valid_next = 1'b0;
                        bad_row_next   = bad_row_reg | row_multi_hot;
                        if (rows_left_reg != '0) begin
                            rows_left_next = rows_left_reg - CNT_W'(1);
                        end
                        if (rows_left_reg <= CNT_W'(1)) begin
                            state_next = DONE;
                        end else begin
                            timer_load = 1'b1;
                            state_next = WAIT_TICK;
                        end
                    end
                end
                DONE: begin
                    row_valid_next = 1'b0;
                    state_next     = IDLE;
                end
                default: begin
                    row_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            endcase
        end

        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    assign row_out   = row_out_reg;
    assign row_valid = row_valid_reg;
    assign rows_left = rows_left_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign bad_row   = bad_row_reg;

endmodule

// File: doc/song_row_streamer.md
Name: song_row_streamer

Overview:
- Consumer end of the packed song vector produced by the song lookup stage.
- Latches a NUM_ROWS x ROW_W packed song on start and replays it one row at a time, one step period apart, with row 0 (MSB nibble) first.
- Each row goes to the tile board over a valid/ready handshake.
- Reports progress, flags malformed rows, and pulses done after the last row is accepted.

Parameters:
- NUM_ROWS, 31, number of rows in the packed song vector.
- ROW_W, 4, bits per row; one-hot key lane or all-zero for rest.
- STEP_CYCLES, 4, clk cycles between a row being accepted (or stream start) and the next row being offered; must be ≥1.
- CNT_W, 5, width of rows_left; equals clog2(NUM_ROWS+1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- song  in  NUM_ROWS*ROW_W  packed song; row 0 in bits [NUM_ROWS*ROW_W-1 -: ROW_W].
- start  in  1  single-cycle request to latch song and begin streaming.
- pause  in  1  freezes the step timer while high.
- row_out  out  ROW_W  current row offered to the board.
- row_valid  out  1  row_out is valid.
- row_ready  in  1  board accepts row_out this cycle.
- rows_left  out  CNT_W  rows not yet accepted.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final row is accepted.
- bad_row  out  1  sticky; an accepted row had more than one bit set.

Behaviour:
- Reset (async, any state): state=IDLE. row_out=0, row_valid=0, rows_left=0, busy=0, done=0, bad_row=0. Shift register=0, timer=0.
- All outputs are registered.
- song is sampled only on a start cycle; later changes to song are ignored until the next start.
- States: IDLE, WAIT_TICK, OFFER, DONE.
- IDLE:
  - start=1 → shreg<=song, rows_left<=NUM_ROWS, timer<=STEP_CYCLES-1, bad_row<=0, go WAIT_TICK.
- WAIT_TICK:
  - pause=1 → hold timer and state.
  - Else if timer==0 → row_out<=shreg top ROW_W bits, row_valid<=1, go OFFER.
  - Else timer decrements.
- Latency: start sampled at edge N gives row_valid high after edge N+1+STEP_CYCLES (no pause). With STEP_CYCLES=1 that is edge N+2.
- OFFER:
  - row_out is held stable while row_valid=1 and row_ready=0. pause does not withdraw a row already offered.
  - On row_valid&row_ready: shreg shifts left by ROW_W, zero fill. rows_left decrements. row_valid<=0. bad_row|=(popcount(row_out)>1).
  - If rows_left was 1 → go DONE. Else timer<=STEP_CYCLES-1, go WAIT_TICK.
- DONE: done=1 for exactly this one cycle, then IDLE. rows_left reads 0. row_valid=0.
- All-zero rows (rests and trailing padding) are streamed like any other row; there is no early termination.
- start in WAIT_TICK/OFFER/DONE restarts the stream: same actions as from IDLE.
  - start has priority over a same-cycle handshake, and that row is not counted as accepted.
  - row_valid is 0 on the next cycle; done is not pulsed.
- row_ready while row_valid=0 is ignored.
- Timer width is clog2(STEP_CYCLES), minimum 1 bit.
- rows_left never underflows; it saturates at 0.

Decomposition:
- Shared package (piano_pkg): ROW_W, NUM_ROWS, packed-song width macro, state encoding localparams (IDLE=0, WAIT_TICK=1, OFFER=2, DONE=3).
- One natural sub-module: step_timer.
  - Loadable down-counter with STEP_CYCLES parameter.
  - Inputs: clk, reset, load, en (=!pause).
  - Output: expired (timer==0).
- The FSM, shift register, and counters stay in song_row_streamer.

Test Plan:
- Reset mid-stream: assert reset while row_valid=1 → outputs go to 0 immediately without waiting for clk; state IDLE; busy=0.
- Normal stream, STEP_CYCLES=4, row_ready tied 1, song = Mary pattern:
  - start at edge 0 → row_valid first high after edge 5 with row_out=0010.
  - Second row 0100 follows STEP_CYCLES+1 cycles later.
  - 31 rows total, the last five are 0000.
  - done pulses once; rows_left steps 31→0.
- Backpressure: hold row_ready=0 for 10 cycles on row 2 → row_out stays 0100, row_valid stays 1, rows_left stays 30. On release, one acceptance; next row 1000.
- Pause: pause=1 for 7 cycles during WAIT_TICK → next row_valid delayed by exactly 7 cycles. pause during OFFER does not drop row_valid.
- Malformed row: row 3 = 0110 → streamed unchanged; bad_row rises after its acceptance and stays 1 until the next start.
- Restart: start asserted in the same cycle as a handshake on row 10 →
  - row_valid is 0 next cycle, rows_left=31, no done pulse.
  - First row of the new song appears after STEP_CYCLES+1 cycles.
